// File: rtl/prom_step_reader.sv
// Step-paced address sequencer and output stage for a Gowin pROM.
// Ports: clk, rst_n, en | rom_ad, rom_dout | out_* valid/ready, wrap, overrun.
module prom_step_reader #(
  parameter int CLK_HZ    = 27000000,
  parameter int STEP_HZ   = 2,
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int LAST_ADDR = 15,
  parameter int READ_LAT  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [ADDR_W-1:0] rom_ad,
  input  logic [DATA_W-1:0] rom_dout,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              wrap,
  output logic              overrun
);

  localparam int TICK_DIV = CLK_HZ / STEP_HZ;
  localparam int CNT_W    = $clog2(TICK_DIV);

  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(LAST_ADDR);
  localparam logic [2:0]        LAT_INIT  = 3'(READ_LAT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_PRESENT
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [CNT_W-1:0]  presc;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        lat_cnt;
  logic              tick;
  logic              load;
  logic              capture;
  logic              hs;
  logic              busy;

  assign tick   = en && (presc == CNT_MAX);
  assign busy   = (state_q != S_IDLE);
  assign rom_ad = addr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (!en || presc == CNT_MAX) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    capture = 1'b0;
    hs      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (tick) begin
          state_d = S_WAIT;
          load    = 1'b1;
        end
      end
      S_WAIT: begin
        // lat_cnt==1 marks the edge where rom_dout is valid
        if (lat_cnt == 3'd1) begin
          state_d = S_PRESENT;
          capture = 1'b1;
        end
      end
      S_PRESENT: begin
        if (out_ready) begin
          state_d = S_IDLE;
          hs      = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      lat_cnt   <= '0;
      addr      <= '0;
      out_data  <= '0;
      out_addr  <= '0;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        lat_cnt <= LAT_INIT;
      end else if (state_q == S_WAIT) begin
        lat_cnt <= lat_cnt - 3'd1;
      end
      if (capture) begin
        out_data  <= rom_dout;
        out_addr  <= addr;
        out_valid <= 1'b1;
      end
      // addr only advances on handoff so rom_ad stays put during a read
      if (hs) begin
        out_valid <= 1'b0;
        addr      <= (addr == ADDR_LAST) ? '0 : addr + 1'b1;
      end
      wrap <= hs && (addr == ADDR_LAST);
      // a tick while busy is dropped and flagged
      if (tick && busy) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prom_step_reader.sv
// Directed bench for prom_step_reader with pipelined ROM models.
// Main DUT READ_LAT=2, plus READ_LAT=1 and 7 instances for latency.
module tb_prom_step_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       out_ready = 1'b0;

  logic [3:0] ad2, ad1, ad7;
  logic [7:0] d2, d1, d7;
  logic [7:0] od2, od1, od7;
  logic [3:0] oa2, oa1, oa7;
  logic       v2, v1, v7;
  logic       w2, w1, w7;
  logic       ov2, ov1, ov7;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  prom_step_reader #(
    .CLK_HZ(20), .STEP_HZ(2), .ADDR_W(4), .DATA_W(8),
    .LAST_ADDR(3), .READ_LAT(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .rom_ad(ad2), .rom_dout(d2),
    .out_data(od2), .out_addr(oa2), .out_valid(v2),
    .out_ready(out_ready), .wrap(w2), .overrun(ov2)
  );

  prom_step_reader #(
    .CLK_HZ(20), .STEP_HZ(2), .ADDR_W(4), .DATA_W(8),
    .LAST_ADDR(3), .READ_LAT(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .rom_ad(ad1), .rom_dout(d1),
    .out_data(od1), .out_addr(oa1), .out_valid(v1),
    .out_ready(out_ready), .wrap(w1), .overrun(ov1)
  );

  prom_step_reader #(
    .CLK_HZ(20), .STEP_HZ(2), .ADDR_W(4), .DATA_W(8),
    .LAST_ADDR(3), .READ_LAT(7)
  ) dut7 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .rom_ad(ad7), .rom_dout(d7),
    .out_data(od7), .out_addr(oa7), .out_valid(v7),
    .out_ready(out_ready), .wrap(w7), .overrun(ov7)
  );

  logic [7:0] p2 [2];
  logic [7:0] p1;
  logic [7:0] p7 [7];

  always @(posedge clk) begin
    p2[0] <= {4'hA, ad2};
    p2[1] <= p2[0];
    p1    <= {4'hA, ad1};
    p7[0] <= {4'hA, ad7};
    for (int k = 1; k < 7; k++) p7[k] <= p7[k-1];
  end

  assign d2 = p2[1];
  assign d1 = p1;
  assign d7 = p7[6];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    en = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    tests_run += 6;
    if (v2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_valid got %b exp 0", v2);
    end
    if (ov2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_overrun got %b exp 0", ov2);
    end
    if (w2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_wrap got %b exp 0", w2);
    end
    if (ad2 !== 4'h0) begin
      tests_failed++;
      $display("FAIL reset_rom_ad got %h exp 0", ad2);
    end
    if (od2 !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_data got %h exp 00", od2);
    end
    if (oa2 !== 4'h0) begin
      tests_failed++;
      $display("FAIL reset_addr got %h exp 0", oa2);
    end
  endtask

  task automatic test_stream();
    logic       ev;
    logic       ew;
    int         k;
    logic [7:0] ed;
    logic [3:0] ea;
    apply_reset();
    out_ready = 1'b1;
    en = 1'b1;
    for (int i = 1; i <= 53; i++) begin
      cyc();
      ev = (i >= 12) && (i % 10 == 2);
      ew = (i == 43);
      tests_run += 3;
      if (v2 !== ev) begin
        tests_failed++;
        $display("FAIL stream_valid cyc=%0d got %b exp %b", i, v2, ev);
      end
      if (w2 !== ew) begin
        tests_failed++;
        $display("FAIL stream_wrap cyc=%0d got %b exp %b", i, w2, ew);
      end
      if (ov2 !== 1'b0) begin
        tests_failed++;
        $display("FAIL stream_overrun cyc=%0d got %b exp 0", i, ov2);
      end
      if (ev) begin
        k = ((i - 12) / 10) % 4;
        ea = 4'(k);
        ed = {4'hA, ea};
        tests_run += 2;
        if (od2 !== ed) begin
          tests_failed++;
          $display("FAIL stream_data cyc=%0d got %h exp %h", i, od2, ed);
        end
        if (oa2 !== ea) begin
          tests_failed++;
          $display("FAIL stream_addr cyc=%0d got %h exp %h", i, oa2, ea);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic ev;
    logic eo;
    apply_reset();
    out_ready = 1'b0;
    en = 1'b1;
    for (int i = 1; i <= 43; i++) begin
      cyc();
      ev = (i >= 12 && i <= 36) || (i == 42);
      eo = (i >= 20);
      tests_run += 2;
      if (v2 !== ev) begin
        tests_failed++;
        $display("FAIL bp_valid cyc=%0d got %b exp %b", i, v2, ev);
      end
      if (ov2 !== eo) begin
        tests_failed++;
        $display("FAIL bp_overrun cyc=%0d got %b exp %b", i, ov2, eo);
      end
      if (i >= 12 && i <= 36) begin
        tests_run++;
        if (od2 !== 8'hA0) begin
          tests_failed++;
          $display("FAIL bp_hold cyc=%0d got %h exp a0", i, od2);
        end
      end
      if (i == 42) begin
        tests_run += 2;
        if (od2 !== 8'hA1) begin
          tests_failed++;
          $display("FAIL bp_next_data got %h exp a1", od2);
        end
        if (oa2 !== 4'h1) begin
          tests_failed++;
          $display("FAIL bp_next_addr got %h exp 1", oa2);
        end
      end
      if (i == 36) out_ready = 1'b1;
    end
  endtask

  task automatic test_en_low();
    apply_reset();
    out_ready = 1'b1;
    en = 1'b1;
    for (int i = 1; i <= 10; i++) cyc();
    en = 1'b0;
    for (int i = 11; i <= 62; i++) begin
      cyc();
      tests_run++;
      if (v2 !== (i == 12)) begin
        tests_failed++;
        $display("FAIL enlow_valid cyc=%0d got %b exp %b", i, v2, i == 12);
      end
      if (i == 12) begin
        tests_run++;
        if (od2 !== 8'hA0) begin
          tests_failed++;
          $display("FAIL enlow_data got %h exp a0", od2);
        end
      end
      if (i >= 13) begin
        tests_run++;
        if (dut.presc !== '0) begin
          tests_failed++;
          $display("FAIL enlow_presc cyc=%0d got %0d exp 0", i, dut.presc);
        end
      end
    end
    en = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      cyc();
      tests_run++;
      if (v2 !== (j == 12)) begin
        tests_failed++;
        $display("FAIL enlow_resume_valid cyc=%0d got %b exp %b", j, v2, j == 12);
      end
    end
    tests_run++;
    if (od2 !== 8'hA1) begin
      tests_failed++;
      $display("FAIL enlow_resume_data got %h exp a1", od2);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    out_ready = 1'b1;
    en = 1'b1;
    for (int i = 1; i <= 20; i++) cyc();
    out_ready = 1'b0;
    for (int i = 21; i <= 31; i++) cyc();
    tests_run += 4;
    if (v2 !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_pre_valid got %b exp 1", v2);
    end
    if (od2 !== 8'hA1) begin
      tests_failed++;
      $display("FAIL mid_pre_data got %h exp a1", od2);
    end
    if (ov2 !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_pre_overrun got %b exp 1", ov2);
    end
    if (ad2 !== 4'h1) begin
      tests_failed++;
      $display("FAIL mid_pre_rom_ad got %h exp 1", ad2);
    end
    rst_n = 1'b0;
    en = 1'b0;
    cyc();
    rst_n = 1'b1;
    tests_run += 4;
    if (v2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_valid got %b exp 0", v2);
    end
    if (ov2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_overrun got %b exp 0", ov2);
    end
    if (ad2 !== 4'h0) begin
      tests_failed++;
      $display("FAIL mid_rom_ad got %h exp 0", ad2);
    end
    if (od2 !== 8'h00) begin
      tests_failed++;
      $display("FAIL mid_data got %h exp 00", od2);
    end
    en = 1'b1;
    out_ready = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      cyc();
      tests_run++;
      if (v2 !== (j == 12)) begin
        tests_failed++;
        $display("FAIL mid_after_valid cyc=%0d got %b exp %b", j, v2, j == 12);
      end
    end
    tests_run += 2;
    if (od2 !== 8'hA0) begin
      tests_failed++;
      $display("FAIL mid_after_data got %h exp a0", od2);
    end
    if (oa2 !== 4'h0) begin
      tests_failed++;
      $display("FAIL mid_after_addr got %h exp 0", oa2);
    end
  endtask

  task automatic test_latency();
    apply_reset();
    out_ready = 1'b1;
    en = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      tests_run += 2;
      if (v1 !== (i == 11)) begin
        tests_failed++;
        $display("FAIL lat1_valid cyc=%0d got %b exp %b", i, v1, i == 11);
      end
      if (v7 !== (i == 17)) begin
        tests_failed++;
        $display("FAIL lat7_valid cyc=%0d got %b exp %b", i, v7, i == 17);
      end
      if (i == 11) begin
        tests_run++;
        if (od1 !== 8'hA0) begin
          tests_failed++;
          $display("FAIL lat1_data got %h exp a0", od1);
        end
      end
      if (i == 17) begin
        tests_run++;
        if (od7 !== 8'hA0) begin
          tests_failed++;
          $display("FAIL lat7_data got %h exp a0", od7);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_en_low();
    test_reset_mid();
    test_latency();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
